// File: rtl/tpc_sram_pkg.sv
// Shared constants, bank swizzle helpers and the read-return tag for the TPC SRAM arbiter.
package tpc_sram_pkg;

  localparam int REQ_DMA   = 0;
  localparam int REQ_MXU   = 1;
  localparam int REQ_VPU   = 2;
  localparam int NUM_BANKS = 4;
  localparam int WORD_W    = 8;
  localparam int REQ_ID_W  = 2;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] req_id;
  } ret_tag_t;

  // XOR swizzle spreads power-of-two strides across banks.
  function automatic logic [1:0] bank_of(input logic [9:0] addr);
    return addr[1:0] ^ addr[9:8];
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [9:0] addr);
    return addr[9:2];
  endfunction

endpackage

// File: rtl/tpc_sram_arbiter_rr.sv
// Round-robin grant over NUM_REQ contenders; the pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [PW-1:0]      gnt_id,
  output logic [PW-1:0]      ptr
);

  logic [PW-1:0] ptr_d, ptr_q;
  int            idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_id    = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/tpc_sram_arbiter.sv
// Banked SRAM arbiter for DMA/MXU/VPU with per-bank round-robin and 1-cycle read return.
// Optional stall counters are built when TPC_SRAM_ARB_PERF_EN is defined.
module tpc_sram_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 20,
  parameter int WORD_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
  output logic [NUM_BANKS-1:0]          bank_en,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*WORD_W-1:0]   bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata
`ifdef TPC_SRAM_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [NUM_REQ*32-1:0]         perf_stall_cnt
`endif
);

  import tpc_sram_pkg::*;

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  addr_a    [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a   [NUM_REQ];
  logic [1:0]         bank_sel  [NUM_REQ];
  logic [NUM_REQ-1:0] cont      [NUM_BANKS];
  logic [NUM_REQ-1:0] gnt       [NUM_BANKS];
  logic               gnt_valid [NUM_BANKS];
  logic [RW-1:0]      gnt_id    [NUM_BANKS];
  logic [RW-1:0]      rr_ptr    [NUM_BANKS];
  ret_tag_t           tag_d     [NUM_BANKS];
  ret_tag_t           tag_q     [NUM_BANKS];
  logic [DATA_W-1:0]  hold_d    [NUM_REQ];
  logic [DATA_W-1:0]  hold_q    [NUM_REQ];

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_a[r]   = req_addr[r*ADDR_W +: ADDR_W];
      wdata_a[r]  = req_wdata[r*DATA_W +: DATA_W];
      bank_sel[r] = bank_of(addr_a[r][9:0]);
    end
  end

  // Contenders are masked during reset so no grant or pointer move happens.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cont[b] = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        cont[b][r] = req_valid[r] && !rst && (int'(bank_sel[r]) == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (cont[b]),
      .gnt       (gnt[b]),
      .gnt_valid (gnt_valid[b]),
      .gnt_id    (gnt_id[b]),
      .ptr       (rr_ptr[b])
    );
  end

  always_comb begin
    req_ready  = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready[r] = gnt[bank_sel[r]][r];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      tag_d[b] = '0;
      if (gnt_valid[b]) begin
        bank_en[b]                         = 1'b1;
        bank_we[b]                         = req_we[gnt_id[b]];
        bank_addr[b*WORD_W +: WORD_W]      = word_of(addr_a[gnt_id[b]][9:0]);
        bank_wdata[b*DATA_W +: DATA_W]     = wdata_a[gnt_id[b]];
        tag_d[b].valid                     = !req_we[gnt_id[b]];
        tag_d[b].req_id                    = gnt_id[b];
      end
    end
  end

  // Each requester owns at most one tag, so the steering below never collides.
  always_comb begin
    rsp_valid = '0;
    for (int r = 0; r < NUM_REQ; r++) hold_d[r] = hold_q[r];
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (tag_q[b].valid && !rst) begin
        rsp_valid[tag_q[b].req_id] = 1'b1;
        hold_d[tag_q[b].req_id]    = bank_rdata[b*DATA_W +: DATA_W];
      end
    end
    for (int r = 0; r < NUM_REQ; r++) rsp_rdata[r*DATA_W +: DATA_W] = hold_d[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) tag_q[b] <= '0;
      for (int r = 0; r < NUM_REQ; r++)   hold_q[r] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) tag_q[b] <= tag_d[b];
      for (int r = 0; r < NUM_REQ; r++)   hold_q[r] <= hold_d[r];
    end
  end

`ifdef TPC_SRAM_ARB_PERF_EN
  logic [31:0] stall_d [NUM_REQ];
  logic [31:0] stall_q [NUM_REQ];

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      stall_d[r] = stall_q[r];
      if (perf_clr) begin
        stall_d[r] = '0;
      end else if (req_valid[r] && !req_ready[r] && (stall_q[r] != 32'hFFFF_FFFF)) begin
        stall_d[r] = stall_q[r] + 32'd1;
      end
      perf_stall_cnt[r*32 +: 32] = stall_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) for (int r = 0; r < NUM_REQ; r++) stall_q[r] <= '0;
    else     for (int r = 0; r < NUM_REQ; r++) stall_q[r] <= stall_d[r];
  end
`endif

endmodule

// File: tb/tb_tpc_sram_arbiter.sv
// Self-checking bench for tpc_sram_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the banked memory and per-bank round-robin order.
module tb_tpc_sram_arbiter;

  localparam int NR = 3;
  localparam int NB = 4;
  localparam int DW = 256;
  localparam int AW = 20;
  localparam int WW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata, rsp_rdata;
  logic [NB-1:0]      bank_en, bank_we;
  logic [NB*WW-1:0]   bank_addr;
  logic [NB*DW-1:0]   bank_wdata, bank_rdata;
  logic               perf_clr;
  logic [NR*32-1:0]   perf_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sram    [NB][256];
  logic [DW-1:0] ref_mem [NB][256];
  logic          sram_init = 1'b0;
  logic [DW+1:0] exp_q [$];

  tpc_sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
`ifdef TPC_SRAM_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

`ifndef TPC_SRAM_ARB_PERF_EN
  assign perf_stall_cnt = '0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bank macros: one-cycle read latency, filled with random content on the first edge.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < 256; w++)
          sram[b][w] <= {8{$urandom()}};
      sram[0][8] <= {{7{$urandom()}}, 32'hDEADBEEF};
      sram_init  <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_en[b]) begin
          if (bank_we[b]) sram[b][bank_addr[b*WW +: WW]] <= bank_wdata[b*DW +: DW];
          else            bank_rdata[b*DW +: DW] <= sram[b][bank_addr[b*WW +: WW]];
        end
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic int m_bank(input logic [AW-1:0] a);
    return (int'(a) % 4) ^ ((int'(a) / 256) % 4);
  endfunction

  function automatic int m_word(input logic [AW-1:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  // Winner is the contender closest to the pointer going upward with wrap.
  function automatic int model_winner(input logic [NR-1:0] cont, input int ptr);
    int best, best_d, d;
    best = -1;
    best_d = NR;
    for (int r = 0; r < NR; r++) begin
      if (cont[r]) begin
        d = (r - ptr + NR) % NR;
        if (d < best_d) begin
          best_d = d;
          best = r;
        end
      end
    end
    return best;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]           = 1'b1;
    req_we[r]              = we;
    req_addr[r*AW +: AW]   = a;
    req_wdata[r*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 20'h000, '0);
    set_req(1, 1'b0, 20'h001, '0);
    set_req(2, 1'b0, 20'h002, '0);
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
    checks++; if (bank_en !== 4'b0000) begin errors++; $display("FAIL reset_bank_en: got %b exp 0000", bank_en); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 000", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (dut.g_bank[0].u_arb.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr0: got %0d exp 0", dut.g_bank[0].u_arb.ptr_q); end
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive_idle();
    set_req(2, 1'b0, 20'h020, '0);
    #1;
    checks++; if (bank_en !== 4'b0001) begin errors++; $display("FAIL single_bank_en: got %b exp 0001", bank_en); end
    checks++; if (bank_addr[7:0] !== 8'd8) begin errors++; $display("FAIL single_bank_addr: got %0d exp 8", bank_addr[7:0]); end
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL single_ready: got %b exp 100", req_ready); end
    checks++; if (bank_we !== 4'b0000) begin errors++; $display("FAIL single_bank_we: got %b exp 0000", bank_we); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (rsp_valid !== 3'b100) begin errors++; $display("FAIL single_rsp_valid: got %b exp 100", rsp_valid); end
    checks++; if (rsp_rdata[2*DW +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_low: got %h exp deadbeef", rsp_rdata[2*DW +: 32]); end
    checks++; if (rsp_rdata[2*DW +: DW] !== sram[0][8]) begin errors++; $display("FAIL single_rsp_word: got %h exp %h", rsp_rdata[2*DW +: DW], sram[0][8]); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_rsp_drop: got %b exp 000", rsp_valid); end
    checks++; if (rsp_rdata[2*DW +: DW] !== sram[0][8]) begin errors++; $display("FAIL single_rsp_hold: got %h exp %h", rsp_rdata[2*DW +: DW], sram[0][8]); end
  endtask

  task automatic test_conflict_write();
    logic [DW-1:0] wd0, wd1;
    wd0 = {8{$urandom()}};
    wd1 = {8{$urandom()}};
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 20'h020, wd0);
    set_req(1, 1'b1, 20'h121, wd1);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL conflict_first_ready: got %b exp 001", req_ready); end
    checks++; if (bank_we !== 4'b0001) begin errors++; $display("FAIL conflict_first_we: got %b exp 0001", bank_we); end
    checks++; if (bank_wdata[0 +: DW] !== wd0) begin errors++; $display("FAIL conflict_first_wdata: got %h exp %h", bank_wdata[0 +: DW], wd0); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL conflict_second_ready: got %b exp 010", req_ready); end
    checks++; if (bank_addr[7:0] !== 8'h48) begin errors++; $display("FAIL conflict_second_addr: got %h exp 48", bank_addr[7:0]); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (dut.g_bank[0].u_arb.ptr_q !== 2'd2) begin errors++; $display("FAIL conflict_ptr: got %0d exp 2", dut.g_bank[0].u_arb.ptr_q); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL conflict_no_rsp: got %b exp 000", rsp_valid); end
    checks++; if (sram[0][8'h48] !== wd1) begin errors++; $display("FAIL conflict_mem: got %h exp %h", sram[0][8'h48], wd1); end
  endtask

  task automatic test_parallel_reads();
    @(negedge clk);
    drive_idle();
    set_req(0, 1'b0, 20'h000, '0);
    set_req(1, 1'b0, 20'h001, '0);
    set_req(2, 1'b0, 20'h002, '0);
    #1;
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL parallel_ready: got %b exp 111", req_ready); end
    checks++; if (bank_en !== 4'b0111) begin errors++; $display("FAIL parallel_bank_en: got %b exp 0111", bank_en); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (rsp_valid !== 3'b111) begin errors++; $display("FAIL parallel_rsp_valid: got %b exp 111", rsp_valid); end
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (rsp_rdata[r*DW +: DW] !== sram[r][0]) begin
        errors++;
        $display("FAIL parallel_rsp_data[%0d]: got %h exp %h", r, rsp_rdata[r*DW +: DW], sram[r][0]);
      end
    end
  endtask

  task automatic test_back_to_back_hammer();
    int ptr, w, prev_w;
    int acc [NR];
    int wait_c [NR];
    int max_wait;
    logic [NR-1:0] exp_rdy;
    do_reset();
    ptr = 0;
    prev_w = -1;
    max_wait = 0;
    for (int r = 0; r < NR; r++) begin acc[r] = 0; wait_c[r] = 0; end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      set_req(0, 1'b0, 20'h000, '0);
      set_req(1, 1'b0, 20'h004, '0);
      set_req(2, 1'b0, 20'h008, '0);
      #1;
      w = model_winner(3'b111, ptr);
      ptr = (w + 1) % NR;
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL hammer_ready[c%0d]: got %b exp %b", c, req_ready, exp_rdy); end
      if (prev_w >= 0) begin
        exp_rdy = '0;
        exp_rdy[prev_w] = 1'b1;
        checks++; if (rsp_valid !== exp_rdy) begin errors++; $display("FAIL hammer_rsp[c%0d]: got %b exp %b", c, rsp_valid, exp_rdy); end
      end
      prev_w = w;
      for (int r = 0; r < NR; r++) begin
        if (req_ready[r]) begin acc[r]++; wait_c[r] = 0; end
        else begin wait_c[r]++; if (wait_c[r] > max_wait) max_wait = wait_c[r]; end
      end
    end
    drive_idle();
    for (int r = 0; r < NR; r++) begin
      checks++; if (acc[r] !== 3) begin errors++; $display("FAIL hammer_accepts[%0d]: got %0d exp 3", r, acc[r]); end
    end
    checks++; if (max_wait > NR - 1) begin errors++; $display("FAIL hammer_wait: got %0d exp <=2", max_wait); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, 20'h000, '0);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL inflight_ready: got %b exp 001", req_ready); end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL inflight_rsp_in_rst: got %b exp 000", rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL inflight_rsp_after: got %b exp 000", rsp_valid); end
    checks++; if (dut.g_bank[0].u_arb.ptr_q !== 2'd0) begin errors++; $display("FAIL inflight_ptr: got %0d exp 0", dut.g_bank[0].u_arb.ptr_q); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL inflight_rdata: got %h exp 0", rsp_rdata); end
  endtask

  task automatic test_random();
    localparam int N = 400;
    int            m_ptr [NB];
    logic          pv [NR];
    logic          pwe [NR];
    logic [AW-1:0] pa [NR];
    logic [DW-1:0] pd [NR];
    logic [DW-1:0] exp_hold [NR];
    int            wait_c [NR];
    logic [NR-1:0] cont, exp_rdy, exp_rv;
    logic [NB-1:0] exp_en, exp_we;
    logic [NB*WW-1:0] exp_baddr;
    logic [NR*DW-1:0] exp_rsp;
    logic [DW+1:0] e;
    int w, bk, wd;
    do_reset();
    for (int b = 0; b < NB; b++) begin
      m_ptr[b] = 0;
      for (int i = 0; i < 256; i++) ref_mem[b][i] = sram[b][i];
    end
    for (int r = 0; r < NR; r++) begin pv[r] = 1'b0; exp_hold[r] = '0; wait_c[r] = 0; end
    exp_q.delete();
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      drive_idle();
      for (int r = 0; r < NR; r++) begin
        if (!pv[r] && c < N && $urandom_range(0, 3) != 0) begin
          pv[r]  = 1'b1;
          pwe[r] = ($urandom_range(0, 2) == 0);
          pa[r]  = AW'($urandom());
          pa[r][7:2] = 6'($urandom_range(0, 3));
          pd[r]  = {8{$urandom()}};
        end
        if (pv[r]) set_req(r, pwe[r], pa[r], pd[r]);
      end
      #1;
      // Responses for reads accepted last cycle.
      exp_rv = '0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_rv[e[DW+1:DW]] = 1'b1;
        exp_hold[e[DW+1:DW]] = e[DW-1:0];
      end
      for (int r = 0; r < NR; r++) exp_rsp[r*DW +: DW] = exp_hold[r];
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid[c%0d]: got %b exp %b", c, rsp_valid, exp_rv); end
      checks++; if (rsp_rdata !== exp_rsp) begin errors++; $display("FAIL rand_rsp_rdata[c%0d]: got %h exp %h", c, rsp_rdata, exp_rsp); end
      // Grants for this cycle.
      exp_rdy = '0; exp_en = '0; exp_we = '0; exp_baddr = '0;
      for (int b = 0; b < NB; b++) begin
        cont = '0;
        for (int r = 0; r < NR; r++) cont[r] = pv[r] && (m_bank(pa[r]) == b);
        w = model_winner(cont, m_ptr[b]);
        if (w >= 0) begin
          m_ptr[b] = (w + 1) % NR;
          exp_rdy[w] = 1'b1;
          exp_en[b]  = 1'b1;
          exp_we[b]  = pwe[w];
          exp_baddr[b*WW +: WW] = WW'(m_word(pa[w]));
          if (pwe[w]) begin
            checks++;
            if (bank_wdata[b*DW +: DW] !== pd[w]) begin errors++; $display("FAIL rand_wdata[c%0d b%0d]: got %h exp %h", c, b, bank_wdata[b*DW +: DW], pd[w]); end
          end
        end
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[c%0d]: got %b exp %b", c, req_ready, exp_rdy); end
      checks++; if (bank_en !== exp_en) begin errors++; $display("FAIL rand_bank_en[c%0d]: got %b exp %b", c, bank_en, exp_en); end
      checks++; if (bank_we !== exp_we) begin errors++; $display("FAIL rand_bank_we[c%0d]: got %b exp %b", c, bank_we, exp_we); end
      checks++; if (bank_addr !== exp_baddr) begin errors++; $display("FAIL rand_bank_addr[c%0d]: got %h exp %h", c, bank_addr, exp_baddr); end
      for (int r = 0; r < NR; r++) begin
        if (pv[r] && !req_ready[r]) wait_c[r]++;
        else wait_c[r] = 0;
        if (wait_c[r] > NR - 1) begin
          checks++; errors++;
          $display("FAIL rand_fairness[c%0d r%0d]: got wait %0d exp <=2", c, r, wait_c[r]);
        end
        if (exp_rdy[r]) begin
          bk = m_bank(pa[r]);
          wd = m_word(pa[r]);
          if (pwe[r]) ref_mem[bk][wd] = pd[r];
          else        exp_q.push_back({2'(r), ref_mem[bk][wd]});
          pv[r] = 1'b0;
        end
      end
    end
    drive_idle();
  endtask

`ifdef TPC_SRAM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      set_req(0, 1'b0, 20'h000, '0);
      set_req(1, 1'b0, 20'h004, '0);
      set_req(2, 1'b0, 20'h008, '0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (perf_stall_cnt[r*32 +: 32] !== 32'd6) begin errors++; $display("FAIL perf_cnt[%0d]: got %0d exp 6", r, perf_stall_cnt[r*32 +: 32]); end
    end
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    checks++; if (perf_stall_cnt !== '0) begin errors++; $display("FAIL perf_clr: got %h exp 0", perf_stall_cnt); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    perf_clr = 1'b0;
    drive_idle();
    test_reset();
    test_single_read();
    test_conflict_write();
    test_parallel_reads();
    test_back_to_back_hammer();
    test_reset_inflight();
    test_random();
`ifdef TPC_SRAM_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
